// File: rtl/reg_file_sb_pkg.sv
// Shared constants and types for the scoreboarded register file.
package LCp;
  localparam int LC_WIDTH = 16;
  localparam int LC_NREG  = 8;

  typedef logic [LC_WIDTH-1:0] word_t;
endpackage

// File: rtl/reg_file_sb_cnt.sv
// Per-register pending-write counter: counts reservations, retires on writes.
module reg_sb_cnt
  import LCp::*;
#(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] cnt,
  output logic          full,
  output logic          nonzero
);
  localparam logic [CW-1:0] PMAX = '1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          inc_acc;

  assign full    = (cnt_q == PMAX);
  assign nonzero = (cnt_q != '0);
  assign cnt     = cnt_q;
  assign inc_acc = inc && !full;

  // A reserve and a write landing together cancel; writes never underflow.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_acc && !dec) begin
      cnt_d = cnt_q + CW'(1);
    end else if (dec && !inc_acc && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/reg_file_sb.sv
// Multi-port register file with a per-register pending-write scoreboard
// and optional write-to-read forwarding.
module reg_file_sb
  import LCp::*;
#(
  parameter int WIDTH  = LC_WIDTH,
  parameter int NREG   = LC_NREG,
  parameter int NRD    = 2,
  parameter int CW     = 2,
  parameter int BYPASS = 1,
  localparam int AW    = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NRD*AW-1:0]    SR,
  input  logic [AW-1:0]        DR,
  input  logic                 LD_REG,
  input  logic [WIDTH-1:0]     BUS_IN,
  input  logic                 RSV,
  input  logic [AW-1:0]        RSV_DR,
  output logic [NRD*WIDTH-1:0] OUT,
  output logic [NRD-1:0]       RDY,
  output logic                 RSV_FULL,
  output logic [NREG-1:0]      BUSY
);
  logic [WIDTH-1:0] regs_q [NREG];
  logic [WIDTH-1:0] regs_d [NREG];
  logic [CW-1:0]    cnt_w  [NREG];
  logic [NREG-1:0]  full_w;

  for (genvar g = 0; g < NREG; g++) begin : g_cnt
    reg_sb_cnt #(.CW(CW)) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .inc     (RSV && (RSV_DR == AW'(g))),
      .dec     (LD_REG && (DR == AW'(g))),
      .cnt     (cnt_w[g]),
      .full    (full_w[g]),
      .nonzero (BUSY[g])
    );
  end

  // Addresses beyond NREG match no register, so their writes fall away.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      regs_d[i] = regs_q[i];
      if (LD_REG && (DR == AW'(i))) begin
        regs_d[i] = BUS_IN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  always_comb begin
    RSV_FULL = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      if (RSV_DR == AW'(i)) begin
        RSV_FULL = full_w[i];
      end
    end
  end

  // Out-of-range reads return 0 and are always ready.
  always_comb begin : read_ports
    logic [AW-1:0]    sr;
    logic             hit;
    logic             fwd;
    logic [WIDTH-1:0] rd;
    logic [CW-1:0]    c;
    OUT = '0;
    RDY = '0;
    for (int p = 0; p < NRD; p++) begin
      sr  = SR[p*AW +: AW];
      hit = 1'b0;
      rd  = '0;
      c   = '0;
      for (int i = 0; i < NREG; i++) begin
        if (sr == AW'(i)) begin
          hit = 1'b1;
          rd  = regs_q[i];
          c   = cnt_w[i];
        end
      end
      fwd = (BYPASS != 0) && LD_REG && (DR == sr) && hit;
      OUT[p*WIDTH +: WIDTH] = fwd ? BUS_IN : rd;
      RDY[p] = !hit || (c == '0) || (fwd && (c == CW'(1)));
    end
  end
endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: forwarding and non-forwarding builds,
// plus a six-register build for out-of-range addressing.
module tb_reg_file_sb;
  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  SR;
  logic [2:0]  DR;
  logic        LD_REG;
  logic [15:0] BUS_IN;
  logic        RSV;
  logic [2:0]  RSV_DR;

  logic [31:0] out_b, out_n, out_6;
  logic [1:0]  rdy_b, rdy_n, rdy_6;
  logic        full_b, full_n, full_6;
  logic [7:0]  busy_b, busy_n;
  logic [5:0]  busy_6;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  reg_file_sb #(.WIDTH(16), .NREG(8), .NRD(2), .CW(2), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .SR(SR), .DR(DR), .LD_REG(LD_REG), .BUS_IN(BUS_IN),
    .RSV(RSV), .RSV_DR(RSV_DR), .OUT(out_b), .RDY(rdy_b), .RSV_FULL(full_b),
    .BUSY(busy_b));

  reg_file_sb #(.WIDTH(16), .NREG(8), .NRD(2), .CW(2), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .SR(SR), .DR(DR), .LD_REG(LD_REG), .BUS_IN(BUS_IN),
    .RSV(RSV), .RSV_DR(RSV_DR), .OUT(out_n), .RDY(rdy_n), .RSV_FULL(full_n),
    .BUSY(busy_n));

  reg_file_sb #(.WIDTH(16), .NREG(6), .NRD(2), .CW(2), .BYPASS(1)) dut6 (
    .clk(clk), .rst(rst), .SR(SR), .DR(DR), .LD_REG(LD_REG), .BUS_IN(BUS_IN),
    .RSV(RSV), .RSV_DR(RSV_DR), .OUT(out_6), .RDY(rdy_6), .RSV_FULL(full_6),
    .BUSY(busy_6));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    LD_REG = 1'b0;
    RSV    = 1'b0;
  endtask

  task automatic set_sr(input logic [2:0] a0, input logic [2:0] a1);
    SR = {a1, a0};
    #1;
  endtask

  initial begin
    rst = 1'b1; SR = '0; DR = '0; LD_REG = 1'b0; BUS_IN = '0; RSV = 1'b0; RSV_DR = '0;
    step(); step();
    rst = 1'b0;
    #1;
    check("reset_busy", {24'd0, busy_b}, 32'h0);
    check("reset_rdy", {30'd0, rdy_b}, 32'h3);
    check("reset_out", out_b, 32'h0);
    check("reset_full", {31'd0, full_b}, 32'h0);

    // Basic write then read
    LD_REG = 1'b1; DR = 3'd3; BUS_IN = 16'h1234;
    step(); idle();
    set_sr(3'd3, 3'd0);
    check("rd_r3_out", {16'd0, out_b[15:0]}, 32'h1234);
    check("rd_r3_rdy", {31'd0, rdy_b[0]}, 32'h1);

    // Same-cycle forwarding vs. none
    LD_REG = 1'b1; DR = 3'd5; BUS_IN = 16'hBEEF;
    set_sr(3'd3, 3'd5);
    check("byp_out1", {16'd0, out_b[31:16]}, 32'hBEEF);
    check("nobyp_out1_old", {16'd0, out_n[31:16]}, 32'h0);
    step(); idle(); #1;
    check("nobyp_out1_new", {16'd0, out_n[31:16]}, 32'hBEEF);

    // Reserve then retire R2
    RSV = 1'b1; RSV_DR = 3'd2;
    step(); idle();
    set_sr(3'd2, 3'd5);
    check("rsv2_busy", {31'd0, busy_b[2]}, 32'h1);
    check("rsv2_rdy_b", {31'd0, rdy_b[0]}, 32'h0);
    check("rsv2_rdy_n", {31'd0, rdy_n[0]}, 32'h0);
    LD_REG = 1'b1; DR = 3'd2; BUS_IN = 16'h00AA;
    #1;
    check("wr2_rdy_byp", {31'd0, rdy_b[0]}, 32'h1);
    check("wr2_out_byp", {16'd0, out_b[15:0]}, 32'h00AA);
    check("wr2_rdy_nobyp", {31'd0, rdy_n[0]}, 32'h0);
    step(); idle(); #1;
    check("wr2_busy_clear", {31'd0, busy_b[2]}, 32'h0);
    check("wr2_rdy_after", {31'd0, rdy_b[0]}, 32'h1);

    // Saturating reservations on R1
    RSV = 1'b1; RSV_DR = 3'd1;
    step(); step(); #1;
    check("r1_two_full", {31'd0, full_b}, 32'h0);
    step(); #1;
    check("r1_three_full", {31'd0, full_b}, 32'h1);
    step(); idle();
    LD_REG = 1'b1; DR = 3'd1; BUS_IN = 16'h0001;
    step();
    check("r1_after_w1", {31'd0, busy_b[1]}, 32'h1);
    step();
    check("r1_after_w2", {31'd0, busy_b[1]}, 32'h1);
    step(); idle(); #1;
    check("r1_after_w3", {31'd0, busy_b[1]}, 32'h0);

    // Reserve and write coincide on R4 with one pending
    RSV = 1'b1; RSV_DR = 3'd4;
    step();
    LD_REG = 1'b1; DR = 3'd4; BUS_IN = 16'h5555;
    step(); idle();
    set_sr(3'd4, 3'd5);
    check("r4_busy", {31'd0, busy_b[4]}, 32'h1);
    check("r4_data", {16'd0, out_b[15:0]}, 32'h5555);
    check("r4_rdy", {31'd0, rdy_b[0]}, 32'h0);
    LD_REG = 1'b1; DR = 3'd4; BUS_IN = 16'h6666;
    step(); idle(); #1;
    check("r4_clear", {31'd0, busy_b[4]}, 32'h0);

    // Reserve R0 while writing R3
    RSV = 1'b1; RSV_DR = 3'd0; LD_REG = 1'b1; DR = 3'd3; BUS_IN = 16'h4321;
    step(); idle();
    set_sr(3'd3, 3'd0);
    check("diff_busy0", {31'd0, busy_b[0]}, 32'h1);
    check("diff_r3", {16'd0, out_b[15:0]}, 32'h4321);
    check("diff_rdy_r0", {31'd0, rdy_b[1]}, 32'h0);
    LD_REG = 1'b1; DR = 3'd0; BUS_IN = 16'h0000;
    step(); idle(); #1;
    check("diff_busy_clear", {24'd0, busy_b}, 32'h0);

    // Out-of-range on the six-register build
    LD_REG = 1'b1; DR = 3'd7; BUS_IN = 16'h7777;
    step(); idle();
    RSV = 1'b1; RSV_DR = 3'd7;
    set_sr(3'd7, 3'd3);
    check("oor_full", {31'd0, full_6}, 32'h0);
    step(); idle(); #1;
    check("oor_out", {16'd0, out_6[15:0]}, 32'h0);
    check("oor_rdy", {31'd0, rdy_6[0]}, 32'h1);
    check("oor_busy", {26'd0, busy_6}, 32'h0);
    check("inr_r7", {16'd0, out_b[15:0]}, 32'h7777);
    LD_REG = 1'b1; DR = 3'd7; BUS_IN = 16'h7777;
    step(); idle();

    // Reset mid-stream drops reservations and ignores a coincident write
    RSV = 1'b1; RSV_DR = 3'd6;
    step();
    RSV_DR = 3'd7;
    step(); idle(); #1;
    check("pre_rst_busy", {24'd0, busy_b}, 32'hC0);
    rst = 1'b1; LD_REG = 1'b1; DR = 3'd3; BUS_IN = 16'hFFFF; RSV = 1'b1; RSV_DR = 3'd5;
    step();
    rst = 1'b0; idle();
    set_sr(3'd3, 3'd5);
    check("rst_busy", {24'd0, busy_b}, 32'h0);
    check("rst_out", out_b, 32'h0);
    check("rst_rdy", {30'd0, rdy_b}, 32'h3);
    check("rst_full", {31'd0, full_b}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
